// File: rtl/serial_operand_serializer_pkg.sv
// Shared definitions for the bit-serial operand serializer.
//   cnt_w()       width of the per-word bit counter for a given operand width
//   bit_order_e   order in which a word's bits leave the shift lanes
package serial_pkg;

    typedef enum logic {
        BIT_LSB_FIRST = 1'b0,
        BIT_MSB_FIRST = 1'b1
    } bit_order_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_shift_lane.sv
// One parallel-load shift register that presents a single bit per cycle.
// Ports:
//   clk, rst  clock (rising edge) and asynchronous active-low reset
//   load      capture data into the lane (wins over shift)
//   shift     advance the lane by one bit
//   data      parallel word to load
//   bit_out   bit currently presented (MSB or LSB end, chosen by MSB_FIRST)
module serial_shift_lane
    import serial_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);

    localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            if (ORDER == BIT_MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    assign bit_out = (ORDER == BIT_MSB_FIRST) ? shreg[WIDTH-1] : shreg[0];

endmodule

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial source for bit-serial arithmetic: takes (A, B) word pairs
// and emits them one bit per cycle with first/last framing.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      input handshake, in_a/in_b operand words
//   out_en                 consumer advance; 0 stalls the stream
//   out_valid              out_a/out_b carry a live bit
//   out_first/out_last     word framing of the current bit
//   out_a/out_b            serial bits, forced to 0 when out_valid is 0
//
// Handshake: a word pair is taken at a rising edge where in_valid && in_ready.
// in_ready depends only on registered state (hold buffer empty), never on
// in_valid, so the producer may use it without a combinational loop. A bit
// is consumed at a rising edge where out_valid && out_en; with out_en low the
// current bit, counter and framing all hold.
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             out_en,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic             out_a,
    output logic             out_b
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;

    logic             accept;
    logic             xfer;
    logic             finishing;
    logic             direct;
    logic             load_lane;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic             bit_a;
    logic             bit_b;

    assign in_ready  = !hold_full;
    assign accept    = in_valid && in_ready;
    assign xfer      = busy && out_en;
    assign finishing = xfer && (cnt == LAST_CNT);

    // A new word bypasses the hold buffer when the lane is idle or is
    // handing off its last bit this cycle. When the hold buffer is full,
    // in_ready is low, so direct and hold-to-lane loads never coincide.
    assign direct    = accept && (!busy || finishing);
    assign load_lane = direct || (finishing && hold_full);
    assign load_a    = hold_full ? hold_a : in_a;
    assign load_b    = hold_full ? hold_b : in_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            hold_full <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
        end else begin
            if (load_lane) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (finishing) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else if (xfer) begin
                cnt  <= cnt + CW'(1);
            end

            if (accept && !direct) begin
                hold_full <= 1'b1;
                hold_a    <= in_a;
                hold_b    <= in_b;
            end else if (finishing && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

    serial_shift_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane_a (
        .clk     (clk),
        .rst     (rst),
        .load    (load_lane),
        .shift   (xfer),
        .data    (load_a),
        .bit_out (bit_a)
    );

    serial_shift_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane_b (
        .clk     (clk),
        .rst     (rst),
        .load    (load_lane),
        .shift   (xfer),
        .data    (load_b),
        .bit_out (bit_b)
    );

    assign out_valid = busy;
    assign out_first = busy && (cnt == '0);
    assign out_last  = busy && (cnt == LAST_CNT);
    assign out_a     = busy && bit_a;
    assign out_b     = busy && bit_b;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer: one MSB-first and one
// LSB-first instance share the same inputs; each has its own expected
// bit-stream queue checked on every falling edge.
module tb_serial_operand_serializer;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_en;

    logic m_ready, m_valid, m_first, m_last, m_a, m_b;
    logic l_ready, l_valid, l_first, l_last, l_a, l_b;

    int n_checks = 0;
    int n_fail   = 0;

    // {bit_a, bit_b, first, last} in emission order
    logic [3:0] m_q[$];
    logic [3:0] l_q[$];
    int m_run = 0, m_max = 0;
    int l_run = 0, l_max = 0;

    serial_operand_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (m_ready), .in_a (in_a), .in_b (in_b),
        .out_en (out_en), .out_valid (m_valid), .out_first (m_first),
        .out_last (m_last), .out_a (m_a), .out_b (m_b)
    );

    serial_operand_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (l_ready), .in_a (in_a), .in_b (in_b),
        .out_en (out_en), .out_valid (l_valid), .out_first (l_first),
        .out_last (l_last), .out_a (l_a), .out_b (l_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // seq_a/seq_b are written in emission order: seq[W-1] leaves first.
    function automatic void push_seq(input bit lsb_dut, input logic [W-1:0] sa, input logic [W-1:0] sb);
        for (int k = W - 1; k >= 0; k--) begin
            if (lsb_dut) l_q.push_back({sa[k], sb[k], k == W - 1, k == 0});
            else         m_q.push_back({sa[k], sb[k], k == W - 1, k == 0});
        end
    endfunction

    function automatic void push_word(input logic [W-1:0] a, input logic [W-1:0] b);
        push_seq(1'b0, a, b);
        push_seq(1'b1, rev(a), rev(b));
    endfunction

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            m_run++;
            if (m_run > m_max) m_max = m_run;
            if (m_q.size() == 0) check("msb_unexpected_bit", 1, 0);
            else begin
                check("msb_bits", {m_a, m_b, m_first, m_last}, m_q[0]);
                if (out_en) void'(m_q.pop_front());
            end
        end else begin
            m_run = 0;
            check("msb_idle_zero", {m_a, m_b, m_first, m_last}, 4'b0);
        end
    end

    always @(negedge clk) begin
        if (l_valid) begin
            l_run++;
            if (l_run > l_max) l_max = l_run;
            if (l_q.size() == 0) check("lsb_unexpected_bit", 1, 0);
            else begin
                check("lsb_bits", {l_a, l_b, l_first, l_last}, l_q[0]);
                if (out_en) void'(l_q.pop_front());
            end
        end else begin
            l_run = 0;
            check("lsb_idle_zero", {l_a, l_b, l_first, l_last}, 4'b0);
        end
    end

    // ---------------- drivers ----------------
    // Leaves in_valid high; the caller lowers it or presents the next word.
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit auto_push, output int waits);
        logic rdy;
        bit   done;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waits    = 0;
        done     = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rdy = m_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
            else     waits++;
        end
        if (!done) check("send_timeout", 0, 1);
        else if (auto_push) push_word(a, b);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #2;
            if (m_q.size() == 0 && l_q.size() == 0 && !m_valid && !l_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w0, w1, w2;
        logic [W-1:0] hm_a, hm_b, hl_a, hl_b;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        out_en   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_msb", {m_valid, m_first, m_last, m_a, m_b}, 5'b0);
        check("reset_outputs_lsb", {l_valid, l_first, l_last, l_a, l_b}, 5'b0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {m_ready, l_ready}, 2'b11);

        // Hand-computed streams for A=6482, B=6262
        hm_a = 16'b0110_0100_1000_0010;
        hm_b = 16'b0110_0010_0110_0010;
        hl_a = 16'b0100_0001_0010_0110;
        hl_b = 16'b0100_0110_0100_0110;
        send_word(16'h6482, 16'h6262, 1'b0, w0);
        in_valid = 1'b0;
        push_seq(1'b0, hm_a, hm_b);
        push_seq(1'b1, hl_a, hl_b);
        check("first_bit_latency", {m_valid, m_first, l_valid, l_first}, 4'b1111);
        wait_drain();

        // Three words back to back with in_valid held high
        m_max = 0;
        l_max = 0;
        send_word(16'hA5C3, 16'h0F0F, 1'b1, w0);
        send_word(16'h1234, 16'hFFFF, 1'b1, w1);
        send_word(16'h8001, 16'h7FFE, 1'b1, w2);
        in_valid = 1'b0;
        check("b2b_w1_waits", w0, 0);
        check("b2b_w2_waits", w1, 0);
        // W3 is refused while hold is full, including the edge where W1's
        // last bit leaves, and taken on the next edge.
        check("b2b_w3_waits", w2, 15);
        check("b2b_ready_low_hold_full", m_ready, 0);
        wait_drain();
        check("b2b_no_bubble_msb", m_max, 48);
        check("b2b_no_bubble_lsb", l_max, 48);

        // Stall for 5 cycles while bit 7 is presented
        send_word(16'hC3A9, 16'h5E17, 1'b1, w0);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        out_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_bit7_msb", {m_valid, m_first, m_last, m_a}, {3'b100, 1'b1});
        check("stall_queue_left", m_q.size(), 9);
        out_en = 1'b1;
        wait_drain();

        // Reset while bit 9 is presented
        send_word(16'hFFFF, 16'hFFFF, 1'b1, w0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_live", {m_valid, m_a, l_valid, l_a}, 4'b1111);
        rst = 1'b0;
        m_q.delete();
        l_q.delete();
        #1;
        check("mid_reset_zero_msb", {m_valid, m_first, m_last, m_a, m_b}, 5'b0);
        check("mid_reset_zero_lsb", {l_valid, l_first, l_last, l_a, l_b}, 5'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", {m_valid, m_ready}, 2'b01);
        send_word(16'h0001, 16'h8000, 1'b1, w0);
        in_valid = 1'b0;
        check("post_reset_first", {m_first, m_a, m_b, l_first, l_a, l_b}, 6'b101110);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
